// File: rtl/i_cache_sa_if.sv
// i_cache_sa_if: CPU fetch port and instruction-memory block-read port of the
// 2-way instruction cache, plus the performance counters it exports.
// The cache instantiates the slave side; the fetch stage / memory side is master.
interface i_cache_sa_if #(
  parameter int BLOCK_WORDS = 4
);
  localparam int WOFF_BITS = $clog2(BLOCK_WORDS);

  logic [31:0]               ADDR;
  logic                      FLUSH;
  logic [31:0]               INSTRUCTION;
  logic                      BUSYWAIT;
  logic                      MEM_READ;
  logic [29-WOFF_BITS:0]     MEM_ADDR;
  logic                      MEM_BUSYWAIT;
  logic [32*BLOCK_WORDS-1:0] MEM_READDATA;
  logic [31:0]               HIT_COUNT;
  logic [31:0]               MISS_COUNT;

  modport slave (
    input  ADDR, FLUSH, MEM_BUSYWAIT, MEM_READDATA,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDR, HIT_COUNT, MISS_COUNT
  );

  modport master (
    output ADDR, FLUSH, MEM_BUSYWAIT, MEM_READDATA,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDR, HIT_COUNT, MISS_COUNT
  );
endinterface

// File: rtl/i_cache_sa.sv
// i_cache_sa: parametrised 2-way set-associative instruction cache with one
// LRU bit per set, single-cycle flush (FENCE.I) and saturating hit/miss
// counters. All cache state changes on the falling edge of CLK; RESET is
// asynchronous and active-low. Line data and tags are deliberately not reset,
// the cleared valid bits make them unreachable.
// The interface BLOCK_WORDS parameter must match the one given here.
module i_cache_sa #(
  parameter int NUM_SETS    = 8,
  parameter int BLOCK_WORDS = 4
) (
  input logic         CLK,
  input logic         RESET,
  i_cache_sa_if.slave bus
);
  localparam int INDEX_BITS = $clog2(NUM_SETS);
  localparam int WOFF_BITS  = $clog2(BLOCK_WORDS);
  localparam int TAG_BITS   = 32 - INDEX_BITS - WOFF_BITS - 2;
  localparam int LINE_BITS  = 32 * BLOCK_WORDS;

  typedef enum logic [1:0] {IDLE, MEM_RD, DISCARD, FILL} state_t;
  state_t state, next_state;

  logic [WOFF_BITS-1:0]  woff;
  logic [INDEX_BITS-1:0] set_idx;
  logic [TAG_BITS-1:0]   tag;

  logic [NUM_SETS-1:0]  valid [2];
  logic [NUM_SETS-1:0]  lru;
  logic [TAG_BITS-1:0]  tag_mem [2][NUM_SETS];
  logic [LINE_BITS-1:0] data_mem [2][NUM_SETS];

  logic                 hit0, hit1, hit;
  logic [LINE_BITS-1:0] hit_line;
  logic                 victim;
  logic                 fill_way;
  logic [LINE_BITS-1:0] fill_buf;
  logic                 discard;
  logic [31:0]          hit_count, miss_count;
  logic                 unused_addr_bits;

  assign woff    = bus.ADDR[WOFF_BITS+1:2];
  assign set_idx = bus.ADDR[INDEX_BITS+WOFF_BITS+1:WOFF_BITS+2];
  assign tag     = bus.ADDR[31:INDEX_BITS+WOFF_BITS+2];
  assign unused_addr_bits = ^bus.ADDR[1:0];

  // The two tags in a set are always distinct, so at most one way hits.
  assign hit0     = valid[0][set_idx] && (tag_mem[0][set_idx] == tag);
  assign hit1     = valid[1][set_idx] && (tag_mem[1][set_idx] == tag);
  assign hit      = hit0 | hit1;
  assign hit_line = hit1 ? data_mem[1][set_idx] : data_mem[0][set_idx];

  assign bus.INSTRUCTION = hit ? hit_line[{woff, 5'b0} +: 32] : 32'h0;
  assign bus.MEM_ADDR    = bus.ADDR[31:WOFF_BITS+2];
  assign bus.HIT_COUNT   = hit_count;
  assign bus.MISS_COUNT  = miss_count;

  // Refill victim: an empty way first (way0 preferred), else the LRU way.
  assign victim = !valid[0][set_idx] ? 1'b0 :
                  (!valid[1][set_idx] ? 1'b1 : lru[set_idx]);

  // State register; reset forces IDLE so MEM_READ drops without a clock edge.
  always_ff @(negedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= next_state;
  end

  // Next state; a flush seen at any point of a refill sends it to DISCARD.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = hit ? IDLE : MEM_RD;
      MEM_RD: begin
        if (discard || bus.FLUSH)   next_state = DISCARD;
        else if (!bus.MEM_BUSYWAIT) next_state = FILL;
      end
      DISCARD: if (!bus.MEM_BUSYWAIT) next_state = IDLE;
      FILL:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // CPU stall and memory request per state; IDLE stalls only on a miss.
  always_comb begin
    bus.BUSYWAIT = 1'b1;
    bus.MEM_READ = 1'b0;
    case (state)
      IDLE:            bus.BUSYWAIT = !hit;
      MEM_RD, DISCARD: bus.MEM_READ = 1'b1;
      default: ;
    endcase
  end

  // Valid/LRU bookkeeping, discard flag and saturating counters; flush wins.
  always_ff @(negedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid[0]   <= '0;
      valid[1]   <= '0;
      lru        <= '0;
      discard    <= 1'b0;
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      discard <= (state == MEM_RD) && (discard || bus.FLUSH);
      if ((state == IDLE) && hit && !bus.FLUSH && (hit_count != 32'hFFFF_FFFF))
        hit_count <= hit_count + 32'd1;
      if ((state == IDLE) && !hit && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
      if (bus.FLUSH) begin
        valid[0] <= '0;
        valid[1] <= '0;
        lru      <= '0;
      end else if ((state == IDLE) && hit) begin
        lru[set_idx] <= hit0;
      end else if (state == FILL) begin
        valid[fill_way][set_idx] <= 1'b1;
        lru[set_idx]             <= ~fill_way;
      end
    end
  end

  // Capture the returned block and victim on entry to FILL, write line in FILL.
  always_ff @(negedge CLK) begin
    if ((state == MEM_RD) && (next_state == FILL)) begin
      fill_buf <= bus.MEM_READDATA;
      fill_way <= victim;
    end
    if (state == FILL) begin
      data_mem[fill_way][set_idx] <= fill_buf;
      tag_mem[fill_way][set_idx]  <= tag;
    end
  end
endmodule

// File: tb/tb_i_cache_sa.sv
// tb_i_cache_sa: scoreboard bench for i_cache_sa. The fetch driver pushes the
// expected instruction of each fetch into a queue; a monitor pops and compares
// whenever the cache presents an instruction (BUSYWAIT low on a pending fetch).
// Memory word k of block b holds {b[23:0], k+1}, so block 0 is 1,2,3,4.
module tb_i_cache_sa;
  localparam int NUM_SETS    = 8;
  localparam int BLOCK_WORDS = 4;
  localparam int MEM_LAT     = 5;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  int checks     = 0;
  int errors     = 0;
  int exp_hits   = 0;
  int exp_misses = 0;

  logic [31:0] exp_instr_q [$];
  string       exp_name_q [$];
  bit          pending = 1'b0;

  logic         mem_busy = 1'b0;
  logic [127:0] mem_data = '0;
  bit           mem_done = 1'b0;
  int           mem_cnt  = 0;

  i_cache_sa_if #(.BLOCK_WORDS(BLOCK_WORDS)) bus ();

  i_cache_sa #(.NUM_SETS(NUM_SETS), .BLOCK_WORDS(BLOCK_WORDS)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  // Free-running clock; the cache acts on the falling edge.
  always #5 CLK = ~CLK;

  assign bus.MEM_BUSYWAIT = mem_busy;
  assign bus.MEM_READDATA = mem_data;

  function automatic logic [127:0] block_data(input logic [27:0] b);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) d[32*k +: 32] = {b[23:0], 8'(k + 1)};
    return d;
  endfunction

  // Instruction memory: busy for MEM_LAT cycles after a request, then data.
  always @(posedge CLK) begin
    if (!bus.MEM_READ) begin
      mem_busy <= 1'b0;
      mem_done <= 1'b0;
    end else if (!mem_busy && !mem_done) begin
      mem_busy <= 1'b1;
      mem_cnt  <= MEM_LAT - 1;
    end else if (mem_busy) begin
      if (mem_cnt == 0) begin
        mem_busy <= 1'b0;
        mem_done <= 1'b1;
        mem_data <= block_data(bus.MEM_ADDR);
      end else begin
        mem_cnt <= mem_cnt - 1;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // Bounded wait on BUSYWAIT (sel 0) or MEM_READ (sel 1) reaching a level.
  task automatic wait_for(input string name, input int sel, input logic level);
    int n = 0;
    while ((((sel == 0) ? bus.BUSYWAIT : bus.MEM_READ) !== level) && (n < 200)) begin
      @(posedge CLK);
      #2;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: timeout, signal still 0x%0h, want 0x%0h",
               name, !level, level);
    end
  endtask

  // One fetch: drive ADDR, expect hit or miss, wait for delivery, check counters.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] instr,
                                input bit exp_hit, input string name);
    @(posedge CLK);
    #1;
    RESET     = 1'b1;
    bus.FLUSH = 1'b0;
    bus.ADDR  = a;
    exp_instr_q.push_back(instr);
    exp_name_q.push_back(name);
    pending = 1'b1;
    #1;
    check_output({name, "_busywait"}, 32'(bus.BUSYWAIT), exp_hit ? 32'd0 : 32'd1);
    if (!exp_hit) begin
      exp_misses++;
      @(negedge CLK);
      @(posedge CLK);
      #2;
      check_output({name, "_mem_read"}, 32'(bus.MEM_READ), 32'd1);
      check_output({name, "_mem_addr"}, 32'(bus.MEM_ADDR), {4'h0, a[31:4]});
    end
    wait_for({name, "_refill"}, 0, 1'b0);
    @(negedge CLK);
    #1;
    pending = 1'b0;
    exp_hits++;
    check_output({name, "_hit_count"}, bus.HIT_COUNT, exp_hits);
    check_output({name, "_miss_count"}, bus.MISS_COUNT, exp_misses);
  endtask

  // Assert reset across one falling edge; the next fetch releases it.
  task automatic do_reset();
    @(posedge CLK);
    #1;
    RESET     = 1'b0;
    bus.FLUSH = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    #1;
    check_output("reset_busywait", 32'(bus.BUSYWAIT), 32'd1);
    check_output("reset_mem_read", 32'(bus.MEM_READ), 32'd0);
    check_output("reset_hit_count", bus.HIT_COUNT, 32'd0);
    check_output("reset_miss_count", bus.MISS_COUNT, 32'd0);
    @(negedge CLK);
    #1;
  endtask

  // Monitor: compare the delivered instruction against the scoreboard.
  initial begin
    logic [31:0] e;
    string       n;
    forever begin
      @(posedge CLK);
      #3;
      if (pending && !bus.BUSYWAIT) begin
        if (exp_instr_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL scoreboard_empty: got 0x%08h, want no delivery",
                   bus.INSTRUCTION);
        end else begin
          e = exp_instr_q.pop_front();
          n = exp_name_q.pop_front();
          check_output({n, "_instr"}, bus.INSTRUCTION, e);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.ADDR  = 32'h0;
    bus.FLUSH = 1'b0;
    #1 RESET  = 1'b0;
    @(negedge CLK);
    #1;
    check_output("init_busywait", 32'(bus.BUSYWAIT), 32'd1);
    check_output("init_mem_read", 32'(bus.MEM_READ), 32'd0);
    check_output("init_instr", bus.INSTRUCTION, 32'h0);
    check_output("init_hit_count", bus.HIT_COUNT, 32'd0);
    check_output("init_miss_count", bus.MISS_COUNT, 32'd0);

    $display("[TB] basic miss then hit");
    apply_stimulus(32'h0000_0000, 32'h0000_0001, 1'b0, "miss_000");
    apply_stimulus(32'h0000_000C, 32'h0000_0004, 1'b1, "hit_00c");

    $display("[TB] set 0 conflict and LRU");
    do_reset();
    apply_stimulus(32'h0000_0000, 32'h0000_0001, 1'b0, "cf_fill_000");
    apply_stimulus(32'h0000_0080, 32'h0000_0801, 1'b0, "cf_fill_080");
    apply_stimulus(32'h0000_0000, 32'h0000_0001, 1'b1, "cf_hit_000");
    apply_stimulus(32'h0000_0100, 32'h0000_1001, 1'b0, "cf_miss_100");
    apply_stimulus(32'h0000_0000, 32'h0000_0001, 1'b1, "cf_hit_000b");
    apply_stimulus(32'h0000_0080, 32'h0000_0801, 1'b0, "cf_miss_080");
    apply_stimulus(32'h0000_0084, 32'h0000_0802, 1'b1, "cf_hit_084");
    apply_stimulus(32'h0000_0008, 32'h0000_0003, 1'b1, "cf_hit_008");

    $display("[TB] flush while hitting");
    @(posedge CLK);
    #1;
    bus.ADDR  = 32'h0;
    bus.FLUSH = 1'b1;
    exp_instr_q.push_back(32'h0000_0001);
    exp_name_q.push_back("flush_hit_000");
    pending = 1'b1;
    #1;
    check_output("flush_busywait", 32'(bus.BUSYWAIT), 32'd0);
    @(negedge CLK);
    #1;
    bus.FLUSH = 1'b0;
    pending   = 1'b0;
    check_output("flush_hit_count", bus.HIT_COUNT, exp_hits);
    check_output("flush_busywait_after", 32'(bus.BUSYWAIT), 32'd1);
    apply_stimulus(32'h0000_0000, 32'h0000_0001, 1'b0, "flush_refetch_000");
    apply_stimulus(32'h0000_0080, 32'h0000_0801, 1'b0, "flush_refetch_080");

    $display("[TB] flush during refill");
    do_reset();
    @(posedge CLK);
    #1;
    RESET    = 1'b1;
    bus.ADDR = 32'h0000_0040;
    exp_instr_q.push_back(32'h0000_0401);
    exp_name_q.push_back("disc_040");
    pending = 1'b1;
    exp_misses++;
    @(posedge CLK);
    #1;
    bus.FLUSH = 1'b1;
    #1;
    check_output("disc_mem_read", 32'(bus.MEM_READ), 32'd1);
    check_output("disc_mem_addr", 32'(bus.MEM_ADDR), 32'h4);
    @(negedge CLK);
    #1;
    bus.FLUSH = 1'b0;
    check_output("disc_busywait", 32'(bus.BUSYWAIT), 32'd1);
    wait_for("disc_drop", 1, 1'b0);
    wait_for("disc_reread", 1, 1'b1);
    exp_misses++;
    check_output("disc_mem_addr2", 32'(bus.MEM_ADDR), 32'h4);
    wait_for("disc_refill", 0, 1'b0);
    @(negedge CLK);
    #1;
    pending = 1'b0;
    exp_hits++;
    check_output("disc_hit_count", bus.HIT_COUNT, exp_hits);
    check_output("disc_miss_count", bus.MISS_COUNT, exp_misses);
    apply_stimulus(32'h0000_0044, 32'h0000_0402, 1'b1, "disc_hit_044");

    $display("[TB] reset during refill");
    @(posedge CLK);
    #1;
    bus.ADDR = 32'h0;
    @(posedge CLK);
    #1;
    check_output("rst_mem_read_before", 32'(bus.MEM_READ), 32'd1);
    RESET = 1'b0;
    #1;
    check_output("rst_mem_read", 32'(bus.MEM_READ), 32'd0);
    check_output("rst_busywait", 32'(bus.BUSYWAIT), 32'd1);
    check_output("rst_instr", bus.INSTRUCTION, 32'h0);
    check_output("rst_hit_count", bus.HIT_COUNT, 32'd0);
    check_output("rst_miss_count", bus.MISS_COUNT, 32'd0);
    exp_hits   = 0;
    exp_misses = 0;
    @(negedge CLK);
    #1;
    apply_stimulus(32'h0000_0000, 32'h0000_0001, 1'b0, "rst_refetch_000");
    apply_stimulus(32'h0000_0040, 32'h0000_0401, 1'b0, "rst_refetch_040");

    check_output("scoreboard_drained", 32'(exp_instr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i_cache_sa.md
Name: i_cache_sa

Overview:
- Parametrised 2-way set-associative instruction cache; next generation of the direct-mapped instruction cache.
- Sits between the CPU fetch stage (PC in, instruction plus stall out) and instruction memory (block-read interface).
- Adds configurable set count and block size, LRU replacement, single-cycle flush (FENCE.I support) and saturating hit/miss counters.

Parameters:
- NUM_SETS, 8, number of sets; power of 2, ≥2. INDEX_BITS = log2(NUM_SETS).
- BLOCK_WORDS, 4, 32-bit words per line; power of 2, ≥2. WOFF_BITS = log2(BLOCK_WORDS).
- TAG_BITS, 32-INDEX_BITS-WOFF_BITS-2, derived; not to be overridden.

Ports:
- CLK  in  1  clock; all cache state updates on negedge CLK.
- RESET  in  1  asynchronous, active-low reset.
- ADDR  in  32  fetch address (PC); ADDR[1:0] ignored.
- FLUSH  in  1  invalidate all lines; sampled at negedge CLK.
- INSTRUCTION  out  32  word selected by ADDR on hit, else 0.
- BUSYWAIT  out  1  stall request to CPU.
- MEM_READ  out  1  block read request to instruction memory.
- MEM_ADDR  out  32-WOFF_BITS-2  block address = ADDR[31:WOFF_BITS+2].
- MEM_BUSYWAIT  in  1  memory busy; low means MEM_READDATA is valid.
- MEM_READDATA  in  32*BLOCK_WORDS  block data; word k at bits [32k+31:32k].
- HIT_COUNT  out  32  saturating hit counter.
- MISS_COUNT  out  32  saturating miss counter.

Behaviour:
- Address split:
  - word offset = ADDR[WOFF_BITS+1:2]
  - index = ADDR[INDEX_BITS+WOFF_BITS+1:WOFF_BITS+2]
  - tag = ADDR[31:INDEX_BITS+WOFF_BITS+2]
  - Defaults: offset ADDR[3:2], index ADDR[6:4], tag ADDR[31:7].
- Per set: two ways, each with a valid bit, tag and BLOCK_WORDS words; plus one LRU bit per set (value = way to evict next).
- Hit (combinational): way w hits when valid[w] is set and tag[w] equals the ADDR tag. Both ways can never hold the same tag. hit = hit0 | hit1.
- States:
  - IDLE: if hit, go to IDLE; otherwise go to MEM_RD.
  - MEM_RD: if FLUSH was seen during this refill, go to DISCARD; else if MEM_BUSYWAIT is low, go to FILL; otherwise stay in MEM_RD.
  - DISCARD: stay while MEM_BUSYWAIT is high, then go to IDLE.
  - FILL: go to IDLE.
- Outputs by state:
  - IDLE: BUSYWAIT = !hit (combinational, same cycle as the address); MEM_READ = 0.
  - MEM_RD and DISCARD: MEM_READ = 1; MEM_ADDR driven from ADDR; BUSYWAIT = 1.
  - FILL: MEM_READ = 0; BUSYWAIT = 1.
- Victim select, made on entry to FILL: first invalid way (way0 if both are invalid), otherwise the way named by LRU.
- FILL writes the whole line, the tag and valid = 1, then sets LRU to the other way.
- LRU on hit: at each negedge in IDLE with hit, LRU[index] is set to the way that did NOT hit.
- Latency:
  - Hit: zero cycles, no stall.
  - Miss: memory latency plus 2 negedges; on return to IDLE the same ADDR hits and BUSYWAIT falls.
- Counters:
  - HIT_COUNT increments at each negedge in IDLE with hit and FLUSH low.
  - MISS_COUNT increments on each IDLE→MEM_RD transition.
  - Both saturate at 32'hFFFF_FFFF.
- FLUSH:
  - At negedge with FLUSH=1, clear all valid and LRU bits in one cycle.
  - In IDLE, no LRU update occurs that cycle.
  - In MEM_RD, set the internal discard flag; the returning block is not written.
  - In FILL, the flush wins and the line is not marked valid.
- Simultaneous FLUSH and hit in IDLE: the instruction is delivered that cycle; invalidation takes effect after the edge.
- ADDR must be held stable by the stalled CPU while BUSYWAIT=1; behaviour otherwise is undefined.
- RESET low (asynchronous, any state, including mid-refill):
  - state goes to IDLE; MEM_READ = 0 immediately.
  - all valid and LRU bits, the discard flag and both counters cleared.
  - BUSYWAIT = 1 (every lookup misses); INSTRUCTION = 0.
  - Line data is not reset.

Test Plan:
- Release RESET, ADDR=0x0000_0000, memory returns 128'h0000_0004_0000_0003_0000_0002_0000_0001 after 5 cycles → BUSYWAIT=1, MEM_READ=1, MEM_ADDR=28'h0; after FILL, INSTRUCTION=0x1, BUSYWAIT=0, MISS_COUNT=1.
- Then ADDR=0x0000_000C → hit in the same cycle, INSTRUCTION=0x4, BUSYWAIT never rises, HIT_COUNT increments.
- Set 0 conflict sequence:
  - Fill 0x000, fill 0x080, hit 0x000, then miss 0x100 → way holding 0x080 evicted.
  - Then 0x000 hits and 0x080 misses; MISS_COUNT=4.
- Line 0x000 valid, pulse FLUSH for one cycle → next fetch of 0x000 misses (MEM_READ=1); HIT_COUNT unchanged on the flush cycle.
- FLUSH asserted while in MEM_RD for 0x040 → block discarded, return to IDLE, second MEM_READ for MEM_ADDR=28'h4, MISS_COUNT=2, then hit.
- Drive RESET low mid-MEM_RD → MEM_READ falls without waiting for CLK, counters 0; after release, 0x000 misses again.
